// File: rtl/revaluate_pkg.sv
// Shared definitions for the revaluate chi serializer slice.
// Contents: state geometry (row / slice / lane sizes), counter widths and
// the serializer FSM state type.
package revaluate_pkg;

  localparam int unsigned ROW_W       = 5;
  localparam int unsigned SLICE_W     = ROW_W * ROW_W;
  localparam int unsigned N_SLICES    = 64;

  // Bit-within-slice counters cover 0..24.
  localparam int unsigned CNT_W       = 5;
  // Slice counters must be able to hold 64, the end-of-frame value.
  localparam int unsigned SLICE_CNT_W = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_DONE
  } state_t;

endpackage

// File: rtl/revaluate_chi_row.sv
// Combinational chi for one bit of a 5-bit row.
// Ports:
//   row - the five bits a[0..4, y] of one row
//   x   - column index 0..4
//   chi - a[x] ^ (~a[(x+1)%5] & a[(x+2)%5])
module revaluate_chi_row
  import revaluate_pkg::*;
(
  input  logic [ROW_W-1:0] row,
  input  logic [2:0]       x,
  output logic             chi
);

  // Doubling the row turns the mod-5 neighbour lookup into a plain offset.
  logic [2*ROW_W-1:0] row2;
  logic [3:0]         xi;

  assign row2 = {row, row};
  assign xi   = {1'b0, x};
  assign chi  = row2[xi] ^ (~row2[xi + 4'd1] & row2[xi + 4'd2]);

endmodule

// File: rtl/revaluate_chi_serializer.sv
// Bit-serial chi stage: accepts the 1600-bit state one bit per beat
// (64 slices of 25 bits, slice-major, bit i = 5*y + x), applies chi per
// row and streams the result with the writer's framing strobes.
// Ports:
//   clk, rst       - clock, synchronous active-low reset
//   start          - one-cycle pulse starting a frame (honoured in IDLE only)
//   in_valid/in_bit/in_ready - serial input handshake
//   pin/en         - registered serial chi bit and its valid
//   co_c25         - with en on bit 24 of every slice
//   co_c64         - with en for every bit of slice 63
//   busy           - frame in progress
//   done           - one-cycle pulse the cycle after the last output bit
module revaluate_chi_serializer
  import revaluate_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic pin,
  output logic en,
  output logic co_c25,
  output logic co_c64,
  output logic busy,
  output logic done
);

  state_t state, state_nxt;

  // Ping-pong slice buffers; fill_sel is written, emit_sel is streamed.
  logic [SLICE_W-1:0]     slice_buf [2];
  logic [1:0]             full;
  logic                   fill_sel, emit_sel;
  logic [CNT_W-1:0]       in_cnt, out_cnt;
  logic [SLICE_CNT_W-1:0] in_slice, out_slice;

  logic accept, emit, in_last, out_last, frame_last, running, chi_bit;
  logic [SLICE_W-1:0] emit_buf;
  logic [ROW_W-1:0]   row;
  logic [2:0]         x_idx, y_idx;

  assign running    = (state == S_FILL) || (state == S_STREAM);
  // DONE still counts as busy: the last output bit is on the port then.
  assign busy       = (state != S_IDLE);
  assign in_ready   = running && (in_slice < SLICE_CNT_W'(N_SLICES)) && !full[fill_sel];
  assign accept     = in_valid && in_ready;
  assign in_last    = (in_cnt == CNT_W'(SLICE_W - 1));

  assign emit       = (state == S_STREAM) && full[emit_sel];
  assign out_last   = (out_cnt == CNT_W'(SLICE_W - 1));
  assign frame_last = (out_slice == SLICE_CNT_W'(N_SLICES - 1));

  assign emit_buf   = slice_buf[emit_sel];
  assign x_idx      = 3'(out_cnt % CNT_W'(ROW_W));
  assign y_idx      = 3'(out_cnt / CNT_W'(ROW_W));

  always_comb begin
    row = '0;
    for (int unsigned r = 0; r < ROW_W; r++) begin
      if (y_idx == 3'(r)) row = emit_buf[r*ROW_W +: ROW_W];
    end
  end

  revaluate_chi_row u_chi_row (
    .row (row),
    .x   (x_idx),
    .chi (chi_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_FILL;
      S_FILL:   if (accept && in_last) state_nxt = S_STREAM;
      S_STREAM: if (emit && out_last && frame_last) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slice_buf[0] <= '0;
      slice_buf[1] <= '0;
      full         <= '0;
      fill_sel     <= 1'b0;
      emit_sel     <= 1'b0;
      in_cnt       <= '0;
      out_cnt      <= '0;
      in_slice     <= '0;
      out_slice    <= '0;
      pin          <= 1'b0;
      en           <= 1'b0;
      co_c25       <= 1'b0;
      co_c64       <= 1'b0;
      done         <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) begin
        full      <= '0;
        fill_sel  <= 1'b0;
        emit_sel  <= 1'b0;
        in_cnt    <= '0;
        out_cnt   <= '0;
        in_slice  <= '0;
        out_slice <= '0;
      end

      // Fill and emit never target the same buffer in one cycle (one needs
      // it empty, the other full), so both flag updates can land together.
      if (accept) begin
        slice_buf[fill_sel][in_cnt] <= in_bit;
        if (in_last) begin
          full[fill_sel] <= 1'b1;
          fill_sel       <= !fill_sel;
          in_cnt         <= '0;
          in_slice       <= in_slice + 1'b1;
        end else begin
          in_cnt <= in_cnt + 1'b1;
        end
      end

      if (emit) begin
        if (out_last) begin
          full[emit_sel] <= 1'b0;
          emit_sel       <= !emit_sel;
          out_cnt        <= '0;
          out_slice      <= out_slice + 1'b1;
        end else begin
          out_cnt <= out_cnt + 1'b1;
        end
      end

      pin    <= emit && chi_bit;
      en     <= emit;
      co_c25 <= emit && out_last;
      co_c64 <= emit && frame_last;
      // Registered so the pulse trails the last en by one cycle.
      done   <= (state == S_DONE);
    end
  end

endmodule
